// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I fetch constants, FSM encodings and fetch-queue entry type
package riscv_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: QDEPTH-entry FIFO of {pc, instr, pred}; ports clk, rst (async), flush (sync), push/push_entry, pop, head, count
module fetch_queue import riscv_pkg::*; #(
  parameter int QDEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem_q [QDEPTH];
  fetch_entry_t mem_d [QDEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = push_entry;
    wr_d = flush ? '0 : wr_q + PW'(push);
    rd_d = flush ? '0 : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR, pred: 1'b0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage (PC, one-outstanding imem reads, fetch queue, redirect); imem_* / redirect_* / id_* ports; STATIC_BTFN_EN enables static backward-taken prediction
module fetch_unit import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_pred_taken
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [1:0] state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, pc_next;
  logic req_q, req_d, ack, push, pop, pred, issue;
  logic [CW-1:0] count, count_nx;
  fetch_entry_t head, push_entry;
  assign ack = imem_ack & req_q;
  assign pop = id_valid & id_ready;
  assign push = ack & (state_q == ST_WAIT) & ~redirect_valid;
`ifdef STATIC_BTFN_EN
  logic [6:0] opc;
  logic [31:0] imm;
  assign opc = imem_rdata[6:0];
  assign pred = (opc == OPC_BRANCH && imem_rdata[31]) || opc == OPC_JAL;
  assign imm = opc == OPC_JAL
    ? {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0}
    : {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign pc_next = pc_q + (pred ? imm : 32'd4);
`else
  assign pred = 1'b0;
  assign pc_next = pc_q + 32'd4;
`endif
  assign push_entry = '{pc: pc_q, instr: imem_rdata, pred: pred};
  // Occupancy after this cycle's push/pop decides whether the next request fits.
  assign count_nx = count + CW'(push) - CW'(pop);
  assign issue = count_nx < CW'(QDEPTH);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_d = req_q;
    addr_d = addr_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'd3;
      // An in-flight request with no ack yet must still complete, at the stale address.
      req_d = state_q != ST_RUN && !ack;
      state_d = req_d ? ST_DRAIN : ST_RUN;
    end else begin
      pc_d = push ? pc_next : pc_q;
      // A completed request hands straight to the next issue so it goes out the cycle after the ack.
      if (state_q == ST_RUN || ack) begin
        req_d = issue;
        addr_d = issue ? pc_d : addr_q;
        state_d = issue ? ST_WAIT : ST_RUN;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      req_q <= req_d;
    end
  end
  fetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .push_entry(push_entry),
    .pop(pop),
    .head(head),
    .count(count)
  );
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign id_valid = count != '0;
  assign id_instr = id_valid ? head.instr : NOP_INSTR;
  assign id_pc = head.pc;
  assign id_pred_taken = id_valid & head.pred;
endmodule
